// File: rtl/rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : rx_fifo
//  Purpose  : Receive FIFO between serial receive logic and an APB-style bus.
//             Words strobed in on rx_valid are queued. Each bus read access
//             (psel && !pwrite) pops the oldest word into a registered
//             prdata one cycle later.
//  Revision : 1.0 - initial release
//
//  Parameters
//    DATA_W      word width
//    DEPTH       number of entries (power of two, >= 2)
//
//  Ports
//    pclk        in   1       sole clock, rising edge
//    clear       in   1       asynchronous active-high reset
//    psel        in   1       bus chip select
//    pwrite      in   1       bus direction, 0 = read
//    rx_valid    in   1       one-cycle strobe, word present on rxdata
//    rxdata      in   DATA_W  received word
//    prdata      out  DATA_W  registered read data
//    rx_empty    out  1       FIFO holds zero words
//    ssprxintr   out  1       FIFO holds DEPTH words
//    ssprorintr  out  1       sticky overrun flag (RX_OVERRUN_EN only)
//
//  Build option
//    RX_OVERRUN_EN  when defined, adds the sticky overrun flag ssprorintr,
//                   set whenever a word arrives into a full FIFO that is
//                   not being read on the same cycle.
// ============================================================================
module rx_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              pclk,
    input  logic              clear,
    input  logic              psel,
    input  logic              pwrite,
    input  logic              rx_valid,
    input  logic [DATA_W-1:0] rxdata,
    output logic [DATA_W-1:0] prdata,
    output logic              rx_empty,
    output logic              ssprxintr
`ifdef RX_OVERRUN_EN
    ,
    output logic              ssprorintr
`endif
);

    localparam int               C_ADDR_W = $clog2(DEPTH);
    localparam logic [C_ADDR_W:0] C_FULL  = (C_ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [C_ADDR_W-1:0] r_wptr;
    logic [C_ADDR_W-1:0] r_rptr;
    logic [C_ADDR_W:0]   r_count;
    logic [DATA_W-1:0]   r_prdata;

    logic w_full;
    logic w_pop;
    logic w_push;

    assign w_full = (r_count == C_FULL);
    assign w_pop  = psel && !pwrite && (r_count != '0);
    // A full FIFO still accepts a word when a pop frees a slot on the same edge.
    assign w_push = rx_valid && (!w_full || w_pop);

    // Storage is not reset: entries are only observable through the
    // occupancy count, which is reset.
    always_ff @(posedge pclk) begin
        if (w_push) begin
            r_mem[r_wptr] <= rxdata;
        end
    end

    // DEPTH is a power of two, so pointer wrap is the natural overflow.
    always_ff @(posedge pclk or posedge clear) begin
        if (clear) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_prdata <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr   <= r_rptr + 1'b1;
                r_prdata <= r_mem[r_rptr];
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign prdata    = r_prdata;
    assign rx_empty  = (r_count == '0);
    assign ssprxintr = w_full;

`ifdef RX_OVERRUN_EN
    logic r_overrun;
    logic w_drop;

    assign w_drop = rx_valid && w_full && !w_pop;

    always_ff @(posedge pclk or posedge clear) begin
        if (clear) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end
    end

    assign ssprorintr = r_overrun;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rx_fifo
//  Purpose  : Self-checking bench for rx_fifo (DATA_W=8, DEPTH=4).
//             Table of per-cycle vectors with expected outputs, hand-written
//             reset sequences, then a randomised phase scored against a
//             queue-based FIFO model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rx_fifo;

    localparam int DW = 8;
    localparam int DP = 4;

    logic          pclk = 1'b0;
    logic          clear;
    logic          psel;
    logic          pwrite;
    logic          rx_valid;
    logic [DW-1:0] rxdata;
    logic [DW-1:0] prdata;
    logic          rx_empty;
    logic          ssprxintr;
`ifdef RX_OVERRUN_EN
    logic          ssprorintr;
`endif

    rx_fifo #(.DATA_W(DW), .DEPTH(DP)) dut (
        .pclk      (pclk),
        .clear     (clear),
        .psel      (psel),
        .pwrite    (pwrite),
        .rx_valid  (rx_valid),
        .rxdata    (rxdata),
        .prdata    (prdata),
        .rx_empty  (rx_empty),
        .ssprxintr (ssprxintr)
`ifdef RX_OVERRUN_EN
        ,
        .ssprorintr(ssprorintr)
`endif
    );

    always #5 pclk = ~pclk;

    typedef struct {
        logic          sel;
        logic          wr;
        logic          vld;
        logic [DW-1:0] data;
        logic [DW-1:0] e_prd;
        logic          e_emp;
        logic          e_int;
        logic          e_ovr;
    } vec_t;

    vec_t vecs[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic v(input logic sel, input logic wr, input logic vld, input logic [DW-1:0] data,
                     input logic [DW-1:0] e_prd, input logic e_emp, input logic e_int,
                     input logic e_ovr);
        vec_t t;
        t.sel = sel; t.wr = wr; t.vld = vld; t.data = data;
        t.e_prd = e_prd; t.e_emp = e_emp; t.e_int = e_int; t.e_ovr = e_ovr;
        vecs.push_back(t);
    endtask

    task automatic drive(input logic sel, input logic wr, input logic vld, input logic [DW-1:0] data);
        psel = sel; pwrite = wr; rx_valid = vld; rxdata = data;
    endtask

    // Advance one rising edge and settle 1 ns after it.
    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    logic [DW-1:0] mq[$];
    logic [DW-1:0] sb[$];
    logic [DW-1:0] held;
    logic          m_ovr;

    initial begin
        // ---------------- vector table --------------------------------------
        // fill / drain
        v(0,0,1,8'h11, 8'h00,0,0,0); v(0,0,1,8'h22, 8'h00,0,0,0);
        v(0,0,1,8'h33, 8'h00,0,0,0); v(0,0,1,8'h44, 8'h00,0,1,0);
        v(1,0,0,8'h00, 8'h11,0,0,0); v(1,0,0,8'h00, 8'h22,0,0,0);
        v(1,0,0,8'h00, 8'h33,0,0,0); v(1,0,0,8'h00, 8'h44,1,0,0);
        // read while empty, write access with and without push, idle
        v(1,0,0,8'h00, 8'h44,1,0,0);
        v(1,1,1,8'hA0, 8'h44,0,0,0); v(1,0,0,8'h00, 8'hA0,1,0,0);
        v(1,1,0,8'h00, 8'hA0,1,0,0); v(0,0,0,8'h00, 8'hA0,1,0,0);
        // wrap-around
        v(0,0,1,8'h01, 8'hA0,0,0,0); v(0,0,1,8'h02, 8'hA0,0,0,0); v(0,0,1,8'h03, 8'hA0,0,0,0);
        v(1,0,0,8'h00, 8'h01,0,0,0); v(1,0,0,8'h00, 8'h02,0,0,0); v(1,0,0,8'h00, 8'h03,1,0,0);
        v(0,0,1,8'hA1, 8'h03,0,0,0); v(0,0,1,8'hA2, 8'h03,0,0,0);
        v(0,0,1,8'hA3, 8'h03,0,0,0); v(0,0,1,8'hA4, 8'h03,0,1,0);
        v(1,0,0,8'h00, 8'hA1,0,0,0); v(1,0,0,8'h00, 8'hA2,0,0,0);
        v(1,0,0,8'h00, 8'hA3,0,0,0); v(1,0,0,8'h00, 8'hA4,1,0,0);
        // push with read while empty: only the push happens
        v(1,0,1,8'h5A, 8'hA4,0,0,0); v(1,0,0,8'h00, 8'h5A,1,0,0);
        // simultaneous push and pop when full
        v(0,0,1,8'h11, 8'h5A,0,0,0); v(0,0,1,8'h22, 8'h5A,0,0,0);
        v(0,0,1,8'h33, 8'h5A,0,0,0); v(0,0,1,8'h44, 8'h5A,0,1,0);
        v(1,0,1,8'h55, 8'h11,0,1,0);
        v(1,0,0,8'h00, 8'h22,0,0,0); v(1,0,0,8'h00, 8'h33,0,0,0);
        v(1,0,0,8'h00, 8'h44,0,0,0); v(1,0,0,8'h00, 8'h55,1,0,0);
        // overrun: word dropped when full and not read
        v(0,0,1,8'h11, 8'h55,0,0,0); v(0,0,1,8'h22, 8'h55,0,0,0);
        v(0,0,1,8'h33, 8'h55,0,0,0); v(0,0,1,8'h44, 8'h55,0,1,0);
        v(0,0,1,8'h99, 8'h55,0,1,1);
        v(1,0,0,8'h00, 8'h11,0,0,1); v(1,0,0,8'h00, 8'h22,0,0,1);
        v(1,0,0,8'h00, 8'h33,0,0,1); v(1,0,0,8'h00, 8'h44,1,0,1);

        // ---------------- reset state ---------------------------------------
        clear = 1'b1;
        drive(0, 0, 0, 8'h00);
        #12;
        chk("reset_prdata", prdata, 8'h00);
        chk("reset_empty", rx_empty, 1'b1);
        chk("reset_intr", ssprxintr, 1'b0);
        @(posedge pclk);
        #1;
        clear = 1'b0;

        // ---------------- table ---------------------------------------------
        foreach (vecs[i]) begin
            drive(vecs[i].sel, vecs[i].wr, vecs[i].vld, vecs[i].data);
            step();
            chk($sformatf("vec%0d_prdata", i), prdata, vecs[i].e_prd);
            chk($sformatf("vec%0d_empty", i), rx_empty, vecs[i].e_emp);
            chk($sformatf("vec%0d_intr", i), ssprxintr, vecs[i].e_int);
`ifdef RX_OVERRUN_EN
            chk($sformatf("vec%0d_ovr", i), ssprorintr, vecs[i].e_ovr);
`endif
        end

        // ---------------- asynchronous clear between edges ------------------
        drive(0, 0, 1, 8'h66);
        step();
        drive(0, 0, 0, 8'h00);
        chk("pre_clear_empty", rx_empty, 1'b0);
        #3;
        clear = 1'b1;
        #1;
        chk("async_clear_prdata", prdata, 8'h00);
        chk("async_clear_empty", rx_empty, 1'b1);
        chk("async_clear_intr", ssprxintr, 1'b0);
`ifdef RX_OVERRUN_EN
        chk("async_clear_ovr", ssprorintr, 1'b0);
`endif

        // ---------------- clear overrides push/pop, first edge after honoured
        drive(1, 0, 1, 8'h77);
        step();
        chk("clear_hold_empty", rx_empty, 1'b1);
        chk("clear_hold_prdata", prdata, 8'h00);
        clear = 1'b0;
        drive(0, 0, 1, 8'h77);
        step();
        chk("post_clear_push_empty", rx_empty, 1'b0);
        drive(1, 0, 0, 8'h00);
        step();
        chk("post_clear_read", prdata, 8'h77);
        chk("post_clear_read_empty", rx_empty, 1'b1);
        drive(0, 0, 0, 8'h00);

        // ---------------- randomised scoreboard phase -----------------------
        held  = 8'h77;
        m_ovr = 1'b0;
        for (int c = 0; c < 300; c++) begin
            logic sel, wr, vld, pop, push;
            logic [DW-1:0] d;
            sel = ($urandom_range(0, 99) < 45);
            wr  = ($urandom_range(0, 99) < 25);
            vld = ($urandom_range(0, 99) < 55);
            d   = DW'($urandom_range(0, 255));
            pop  = sel && !wr && (mq.size() > 0);
            push = vld && (mq.size() < DP || pop);
            if (pop) sb.push_back(mq.pop_front());
            if (push) mq.push_back(d);
            if (vld && !push) m_ovr = 1'b1;
            drive(sel, wr, vld, d);
            step();
            if (sb.size() > 0) held = sb.pop_front();
            chk("rand_prdata", prdata, held);
            chk("rand_empty", rx_empty, mq.size() == 0);
            chk("rand_intr", ssprxintr, mq.size() == DP);
`ifdef RX_OVERRUN_EN
            chk("rand_ovr", ssprorintr, m_ovr);
`endif
        end
        drive(0, 0, 0, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rx_fifo.md
RX_FIFO -- requirements
Module: rx_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 8, word width.
REQ-002 SHALL have parameter DEPTH, default 4, number of entries (power of two, >= 2).
REQ-003 SHALL have port pclk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port clear  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port psel  input  1  bus chip select.
REQ-006 SHALL have port pwrite  input  1  bus direction; 0 = read access.
REQ-007 SHALL have port rx_valid  input  1  one-cycle strobe from receive logic, word present on rxdata.
REQ-008 SHALL have port rxdata  input  DATA_W  received word.
REQ-009 SHALL have port prdata  output  DATA_W  registered read data to bus.
REQ-010 SHALL have port rx_empty  output  1  high when FIFO holds zero words.
REQ-011 SHALL have port ssprxintr  output  1  receive interrupt, high when FIFO holds DEPTH words.
REQ-012 SHALL have port ssprorintr  output  1  sticky overrun flag, present only when RX_OVERRUN_EN is defined.

Function
REQ-013 SHALL hold storage array, write pointer, read pointer (log2(DEPTH) bits, wrap DEPTH-1 -> 0) and occupancy count (log2(DEPTH)+1 bits, range 0..DEPTH).
REQ-014 SHALL define push = rx_valid && (count < DEPTH || pop).
REQ-015 SHALL define pop = psel && !pwrite && count > 0.
REQ-016 On push, SHALL write rxdata to mem[wptr] and increment wptr at the same edge.
REQ-017 On pop, SHALL load prdata <= mem[rptr] and increment rptr at the same edge; read latency one cycle from the sampled access.
REQ-018 SHALL hold prdata unchanged on cycles without pop, including read access while empty.
REQ-019 SHALL update count: +1 push only, -1 pop only, unchanged for both or neither.
REQ-020 Simultaneous push and pop when full SHALL both succeed; count stays DEPTH, oldest word read out, new word stored.
REQ-021 Simultaneous push and pop when empty SHALL be impossible (pop requires count > 0); only push takes effect, count -> 1.
REQ-022 rx_valid while full without pop SHALL drop the word; pointers, count and storage unchanged.
REQ-023 rx_empty SHALL equal (count == 0); ssprxintr SHALL equal (count == DEPTH); both decoded from registered count, no combinational path from inputs.
REQ-024 psel && pwrite SHALL have no effect on FIFO state.

Reset
REQ-025 clear high SHALL immediately, without a clock edge, set wptr = 0, rptr = 0, count = 0, prdata = 0, ssprxintr = 0, rx_empty = 1, ssprorintr = 0.
REQ-026 Storage contents SHALL NOT require reset; stale entries SHALL never be observable because count = 0.
REQ-027 clear asserted mid-operation SHALL override any push/pop on that edge; first push/pop after deassertion SHALL be honoured on the first rising edge with clear low.

Configuration
REQ-028 Macro RX_OVERRUN_EN SHALL control the overrun feature.
REQ-029 With RX_OVERRUN_EN defined: ssprorintr SHALL set on the edge where a word is dropped per REQ-022 and remain high until clear.
REQ-030 Without RX_OVERRUN_EN: port ssprorintr and its register SHALL be absent; dropped words SHALL be silent; all other behaviour identical.

Verification
REQ-031 Reset: assert clear asynchronously between edges -> prdata=0x00, rx_empty=1, ssprxintr=0 before next edge.
REQ-032 Fill/drain: push 0x11,0x22,0x33,0x44 -> ssprxintr=1 after 4th edge; four reads -> prdata 0x11,0x22,0x33,0x44 each one cycle after access, rx_empty=1 after last.
REQ-033 Wrap-around: push 3, pop 3, push 0xA1..0xA4, pop 4 -> prdata 0xA1..0xA4 in order, count back to 0.
REQ-034 Full simultaneous: full with 0x11..0x44, pop with push 0x55 same cycle -> prdata=0x11, ssprxintr stays 1, subsequent reads 0x22,0x33,0x44,0x55.
REQ-035 Overrun: full with 0x11..0x44, push 0x99 without read -> word dropped, reads return 0x11..0x44; ssprorintr=1 with RX_OVERRUN_EN, port absent without.
REQ-036 Empty read and write access: read with count=0 -> prdata holds prior value, rx_empty stays 1; psel&&pwrite during push -> only push effect observed.
